// File: rtl/tick_sched_pkg.sv
// Shared constants and width helpers for the tick scheduler and its channels.
package tick_sched_pkg;

    localparam logic [0:0] CH_IDLE = 1'b0;
    localparam logic [0:0] CH_RUN  = 1'b1;

    localparam logic MODE_PERIODIC = 1'b0;
    localparam logic MODE_ONESHOT  = 1'b1;

    // Ceiling log2; 0 for values of 0 or 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned v;
        result = 0;
        v = 1;
        while (v < value) begin
            v = v << 1;
            result = result + 1;
        end
        return result;
    endfunction

    // Index width that never collapses to zero bits.
    function automatic int unsigned idx_w(input int unsigned value);
        return (clog2(value) == 0) ? 1 : clog2(value);
    endfunction

endpackage

// File: rtl/tick_channel.sv
// One scheduler channel: IDLE/RUN FSM, base-tick down-counter, mode latch and
// registered single-cycle enable pulse.
module tick_channel
    import tick_sched_pkg::*;
#(
    parameter int unsigned PERIOD_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick_evt,
    input  logic                load,
    input  logic [PERIOD_W-1:0] cfg_period,
    input  logic                cfg_oneshot,
    input  logic                cfg_start,
    output logic                tick_out,
    output logic                busy
);

    logic [0:0]          state, state_d;
    logic [PERIOD_W-1:0] cnt, cnt_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic                mode, mode_d;
    logic                tick_d;
    logic                busy_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= CH_IDLE;
            cnt      <= '0;
            period_q <= '0;
            mode     <= MODE_PERIODIC;
            tick_out <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            period_q <= period_d;
            mode     <= mode_d;
            tick_out <= tick_d;
            busy     <= busy_d;
        end
    end

    // A config write always wins over a coincident base tick.
    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        period_d = period_q;
        mode_d   = mode;
        tick_d   = 1'b0;

        if (load) begin
            if (cfg_start && (cfg_period != '0)) begin
                state_d  = CH_RUN;
                cnt_d    = cfg_period;
                period_d = cfg_period;
                mode_d   = cfg_oneshot;
            end else begin
                state_d = CH_IDLE;
                cnt_d   = '0;
            end
        end else begin
            case (state)
                CH_RUN: begin
                    if (tick_evt) begin
                        if (cnt == PERIOD_W'(1)) begin
                            tick_d = 1'b1;
                            if (mode == MODE_ONESHOT) begin
                                state_d = CH_IDLE;
                                cnt_d   = '0;
                            end else begin
                                cnt_d = period_q;
                            end
                        end else begin
                            cnt_d = cnt - PERIOD_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = CH_IDLE;
                end
            endcase
        end

        busy_d = (state_d == CH_RUN);
    end

endmodule

// File: rtl/tick_scheduler.sv
// Shared timebase: free-running prescaler producing a base tick, plus N_CH
// software-configured periodic/one-shot enable channels in the clk domain.
module tick_scheduler
    import tick_sched_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ  = 100_000_000,
    parameter int unsigned BASE_TICK_HZ = 1_000,
    parameter int unsigned N_CH         = 4,
    parameter int unsigned PERIOD_W     = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [idx_w(N_CH)-1:0] cfg_ch,
    input  logic [PERIOD_W-1:0]    cfg_period,
    input  logic                   cfg_oneshot,
    input  logic                   cfg_start,
    output logic                   base_tick,
    output logic [N_CH-1:0]        tick_out,
    output logic [N_CH-1:0]        busy
);

    localparam int unsigned PRESCALE = CLK_FREQ_HZ / BASE_TICK_HZ;
    localparam int unsigned PS_W     = idx_w(PRESCALE);
    localparam int unsigned CH_W     = idx_w(N_CH);

    generate
        if ((PRESCALE < 2) || ((CLK_FREQ_HZ % BASE_TICK_HZ) != 0)) begin : g_bad_prescale
            $error("tick_scheduler: PRESCALE must be >= 2 and CLK_FREQ_HZ / BASE_TICK_HZ exact");
        end
        if ((N_CH < 1) || (N_CH > 16)) begin : g_bad_nch
            $error("tick_scheduler: N_CH must be in 1..16");
        end
    endgenerate

    logic [PS_W-1:0] pcnt;
    logic            tick_evt_c;
    logic [N_CH-1:0] load_c;

    assign tick_evt_c = (pcnt == PS_W'(PRESCALE - 1));

    // Prescaler never restarts on config writes; only rst realigns it.
    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt      <= '0;
            base_tick <= 1'b0;
            cfg_ready <= 1'b0;
        end else begin
            pcnt      <= tick_evt_c ? '0 : pcnt + PS_W'(1);
            base_tick <= tick_evt_c;
            cfg_ready <= 1'b1;
        end
    end

    // Out-of-range channel indices match no strobe, so those writes vanish.
    for (genvar i = 0; i < int'(N_CH); i++) begin : g_ch
        assign load_c[i] = cfg_valid && cfg_ready && (cfg_ch == CH_W'(i));

        tick_channel #(
            .PERIOD_W (PERIOD_W)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .tick_evt    (tick_evt_c),
            .load        (load_c[i]),
            .cfg_period  (cfg_period),
            .cfg_oneshot (cfg_oneshot),
            .cfg_start   (cfg_start),
            .tick_out    (tick_out[i]),
            .busy        (busy[i])
        );
    end

endmodule

// File: doc/tick_scheduler.md
# tick_scheduler

Shared timebase scheduler for game logic. One prescaler runs from the 100 MHz system clock and produces a base tick, and up to N_CH independent software-configured channels count base ticks. Each channel emits single-cycle clock-enable pulses, either periodic or one-shot. It replaces per-consumer derived clocks, such as sprite animation, physics step and stopwatch digit refresh, with enables in the single `clk` domain.

## Interface
Parameters:
- `CLK_FREQ_HZ`, 100_000_000, input clock frequency.
- `BASE_TICK_HZ`, 1_000, base tick rate.
  - `PRESCALE = CLK_FREQ_HZ / BASE_TICK_HZ`.
  - `PRESCALE` must be ≥ 2 and the division must be exact; otherwise elaboration fails.
- `N_CH`, 4, number of channels (1..16).
- `PERIOD_W`, 16, width of the channel period in base ticks.

Ports:
- `clk` in 1: system clock, 100 MHz.
- `rst` in 1: reset, synchronous, active-high.
- `cfg_valid` in 1: config write request.
- `cfg_ready` out 1: scheduler can accept a config write.
- `cfg_ch` in `clog2(N_CH)` (min 1): target channel index.
- `cfg_period` in `PERIOD_W`: period in base ticks.
- `cfg_oneshot` in 1: 1 = one-shot, 0 = periodic.
- `cfg_start` in 1: 1 = start/restart channel, 0 = stop channel.
- `base_tick` out 1: one-cycle pulse every `PRESCALE` clocks.
- `tick_out` out `N_CH`: per-channel one-cycle enable pulse.
- `busy` out `N_CH`: channel is in RUN.

## Operation
- Reset values: all outputs 0, i.e. `cfg_ready`, `base_tick`, `tick_out`, `busy`. The prescaler count and all channel counters are also 0, and all channels are IDLE.
- Prescaler: counts 0..`PRESCALE-1` and wraps to 0. `base_tick` is registered and high for exactly the one cycle after the count equals `PRESCALE-1`.
- Config handshake: a write is accepted on a rising `clk` edge with `cfg_valid && cfg_ready`.
  - `cfg_ready` is registered: 0 during reset and in the first cycle after `rst` falls, then 1.
  - Each accepted cycle takes exactly one write.
  - `cfg_ch ≥ N_CH`: the write is accepted and ignored.
- Channel FSM, per channel, states IDLE and RUN:
  - IDLE → RUN: accepted write with `cfg_start=1` and `cfg_period≠0`. The counter is loaded with `cfg_period` and the mode is latched.
  - Any state → IDLE: accepted write with `cfg_start=0`, or with `cfg_period=0`. Any pending pulse is dropped.
  - RUN → RUN restart: accepted `cfg_start=1` write. The counter is reloaded and the mode is re-latched, so the phase restarts from the write.
  - RUN on base tick with counter > 1: the counter decrements.
  - RUN on base tick with counter == 1: the channel fires. Periodic mode reloads the latched period and stays in RUN. One-shot mode goes to IDLE and `busy` drops.
- Simultaneous accepted write and base tick on the same channel: the write wins. The counter is loaded, that base tick is not counted, and no fire occurs.
- Writes to other channels do not disturb a channel's count.
- Prescaler is free-running: config writes never reset it, so the first fire after a start arrives within (P-1)·PRESCALE+1 .. P·PRESCALE clocks.
- Counters are unsigned `PERIOD_W` bits and never underflow; 0 is only held in IDLE.
- `rst` mid-operation: returns every register to its reset value on the next edge. A pulse that was due is lost.

## Timing
- Internal base tick event: the cycle where the prescaler count equals `PRESCALE-1`.
- `base_tick` output: asserted the cycle after that event.
- `tick_out[i]`: registered, asserted in the same cycle as `base_tick`, for exactly 1 cycle. The latency from the base tick event is 1 clock.
- `busy[i]`: rises the cycle after the accepting edge. For one-shot mode it falls in the same cycle as the final `tick_out[i]`.
- Periodic spacing: exactly P·`PRESCALE` clocks between consecutive `tick_out[i]` pulses.

## Structure
- Package `tick_sched_pkg`:
  - `clog2` function.
  - Channel state constants `CH_IDLE` and `CH_RUN`.
  - Mode constants `MODE_PERIODIC=0` and `MODE_ONESHOT=1`.
- Sub-module `tick_channel`: FSM, counter, mode latch and output register for one channel, instantiated `N_CH` times in a generate loop.
- Top level keeps the prescaler, the `cfg_ready` register and the `cfg_ch` decode, which produces a per-channel load strobe.

## Test plan
Bench parameters: `CLK_FREQ_HZ=100`, `BASE_TICK_HZ=10` (`PRESCALE=10`), `N_CH=4`, `PERIOD_W=8`.
- Reset release, then idle for 50 clocks -> `base_tick` every 10 clocks, `cfg_ready` high from the 2nd cycle, `tick_out=0`, `busy=0`.
- Ch0 periodic, P=3 -> pulses exactly 30 clocks apart, each coincident with `base_tick`; `busy[0]` stays 1.
- Ch1 one-shot, P=2 -> exactly one `tick_out[1]`; `busy[1]` falls with it; no further pulses in 100 clocks.
- Write ch2 P=1 in the base-tick-event cycle -> no pulse on that tick; first `tick_out[2]` on the next `base_tick`.
- Ch0 running, then write ch0 `cfg_start=0`, then `cfg_period=0` to ch3 -> ch0 stops, ch3 stays IDLE, other channels unaffected.
- Assert `rst` for 1 cycle while ch0 and ch1 are running -> all outputs 0 next cycle; `cfg_ready` returns after 1 cycle.
